// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
//   state_t     : responder FSM states (IDLE, WAIT, RESP)
//   ByteLanes   : byte lanes per word (fixed at 4, so the bus is 32 bits)
//   MaxLatency  : largest supported acceptance-to-response latency
//   CntWidth    : width of the latency down-counter (holds MaxLatency-1)
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int ByteLanes  = 4;
    localparam int MaxLatency = 8;
    localparam int CntWidth   = 3;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous RAM with per-byte write enables and a
// registered read port.
//   i_clk    : clock, rising edge
//   i_rst_n  : async active-low reset; clears only the read register
//   i_en     : access strobe for this edge
//   i_we     : 1 = write enabled lanes, 0 = read full word
//   i_be     : byte-lane write enables
//   i_addr   : word address
//   i_wdata  : write data, lane-aligned
//   o_rdata  : registered read data; holds until the next read access
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 10
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic                 i_we,
    input  logic [ByteLanes-1:0] i_be,
    input  logic [AddrWidth-1:0] i_addr,
    input  logic [DataWidth-1:0] i_wdata,
    output logic [DataWidth-1:0] o_rdata
);

    localparam int Depth = 1 << AddrWidth;

    logic [DataWidth-1:0] r_mem [0:Depth-1];
    logic [DataWidth-1:0] r_rdata;

    // Storage is deliberately not reset so it maps onto a plain RAM macro.
    always_ff @(posedge i_clk) begin
        if (i_en && i_we) begin
            for (int i = 0; i < ByteLanes; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read register only moves on reads, so store traffic leaves it intact.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_en && !i_we) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the memory-stage bus. Accepts one
// load/store at a time, waits Latency edges, then commits a byte-masked store
// or returns a load word with a one-cycle data_valid pulse.
//   clk        : clock, rising edge
//   rst        : async active-low reset
//   request    : transaction request (accepted only in IDLE)
//   we_re      : 1 = store, 0 = load
//   mask       : byte-lane write enables (ignored for loads)
//   address    : byte address; word index is address[AddrWidth+1:2]
//   data_in    : lane-aligned store data
//   data_out   : registered load data, held until the next load response
//   data_valid : one-cycle response pulse for loads and stores
//   busy       : high while a transaction is in flight
//   access_err : (DMEM_BOUNDS_EN only) pulses with data_valid when the
//                address has nonzero bits above AddrWidth+1
// Build option: define DMEM_BOUNDS_EN to add range checking and access_err;
// without it upper address bits are ignored and addresses wrap.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for a request
// WAIT  | counting down remaining latency
// RESP  | response presented for one cycle (data_valid, busy high)
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 10,
    parameter int Latency   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 request,
    input  logic                 we_re,
    input  logic [ByteLanes-1:0] mask,
    input  logic [DataWidth-1:0] address,
    input  logic [DataWidth-1:0] data_in,
    output logic [DataWidth-1:0] data_out,
    output logic                 data_valid,
    output logic                 busy
`ifdef DMEM_BOUNDS_EN
    ,
    output logic                 access_err
`endif
);

    state_t                r_state;
    state_t                w_next;
    logic [CntWidth-1:0]   r_cnt;
    logic                  r_we;
    logic [ByteLanes-1:0]  r_mask;
    logic [AddrWidth-1:0]  r_idx;
    logic [DataWidth-1:0]  r_wdata;

    logic                  w_accept;
    logic                  w_enter_resp;
    logic [AddrWidth-1:0]  w_live_idx;

    logic                  w_acc_we;
    logic [ByteLanes-1:0]  w_acc_mask;
    logic [AddrWidth-1:0]  w_acc_idx;
    logic [DataWidth-1:0]  w_acc_wdata;
    logic                  w_acc_oob;
    logic                  w_ram_en;
    logic [DataWidth-1:0]  w_rdata;

    assign w_live_idx = address[AddrWidth+1:2];

    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        case (r_state)
            IDLE: begin
                if (request) begin
                    w_accept = 1'b1;
                    if (Latency == 1) begin
                        w_next       = RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == CntWidth'(1)) begin
                    w_next       = RESP;
                    w_enter_resp = 1'b1;
                end
            end
            RESP: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_mask  <= '0;
            r_idx   <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt   <= CntWidth'(Latency - 1);
                r_we    <= we_re;
                r_mask  <= mask;
                r_idx   <= w_live_idx;
                r_wdata <= data_in;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // With Latency=1 the array access happens on the acceptance edge itself,
    // before the capture registers are loaded, so the live inputs are used.
    assign w_acc_we    = (r_state == IDLE) ? we_re      : r_we;
    assign w_acc_mask  = (r_state == IDLE) ? mask       : r_mask;
    assign w_acc_idx   = (r_state == IDLE) ? w_live_idx : r_idx;
    assign w_acc_wdata = (r_state == IDLE) ? data_in    : r_wdata;

`ifdef DMEM_BOUNDS_EN
    logic r_oob;
    logic r_zero_out;
    logic w_live_oob;
    logic w_unused;

    assign w_live_oob = |address[DataWidth-1:AddrWidth+2];
    assign w_acc_oob  = (r_state == IDLE) ? w_live_oob : r_oob;
    assign w_unused   = ^address[1:0];

    // r_zero_out remembers that the latest load was out of range, so the
    // output reads 0 until the next load replaces it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_oob      <= 1'b0;
            r_zero_out <= 1'b0;
        end else begin
            if (w_accept) begin
                r_oob <= w_live_oob;
            end
            if (w_enter_resp && !w_acc_we) begin
                r_zero_out <= w_acc_oob;
            end
        end
    end

    assign data_out   = r_zero_out ? '0 : w_rdata;
    assign access_err = (r_state == RESP) && r_oob;
`else
    logic w_unused;

    assign w_acc_oob = 1'b0;
    assign w_unused  = ^{address[DataWidth-1:AddrWidth+2], address[1:0]};
    assign data_out  = w_rdata;
`endif

    assign w_ram_en   = w_enter_resp && !w_acc_oob;
    assign data_valid = (r_state == RESP);
    assign busy       = (r_state != IDLE);

    dmem_array #(
        .DataWidth (DataWidth),
        .AddrWidth (AddrWidth)
    ) u_array (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_en    (w_ram_en),
        .i_we    (w_acc_we),
        .i_be    (w_acc_mask),
        .i_addr  (w_acc_idx),
        .i_wdata (w_acc_wdata),
        .o_rdata (w_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: drives a Latency=1 and a Latency=3 responder, checks
// every cycle against a timestamp-based transaction model, and pins the
// model with literal expectations from hand-worked cases.
module tb_dmem_responder;

    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        req    [2];
    logic        we     [2];
    logic [3:0]  msk    [2];
    logic [31:0] adr    [2];
    logic [31:0] din    [2];
    logic [31:0] dout_s [2];
    logic        valid_s[2];
    logic        busy_s [2];
    logic        err_s  [2];

    int lat[2] = '{1, 3};
    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    dmem_responder #(.DataWidth(32), .AddrWidth(AW), .Latency(1)) u_dut1 (
`ifdef DMEM_BOUNDS_EN
        .access_err (err_s[0]),
`endif
        .clk        (clk),
        .rst        (rst),
        .request    (req[0]),
        .we_re      (we[0]),
        .mask       (msk[0]),
        .address    (adr[0]),
        .data_in    (din[0]),
        .data_out   (dout_s[0]),
        .data_valid (valid_s[0]),
        .busy       (busy_s[0])
    );

    dmem_responder #(.DataWidth(32), .AddrWidth(AW), .Latency(3)) u_dut3 (
`ifdef DMEM_BOUNDS_EN
        .access_err (err_s[1]),
`endif
        .clk        (clk),
        .rst        (rst),
        .request    (req[1]),
        .we_re      (we[1]),
        .mask       (msk[1]),
        .address    (adr[1]),
        .data_in    (din[1]),
        .data_out   (dout_s[1]),
        .data_valid (valid_s[1]),
        .busy       (busy_s[1])
    );

`ifndef DMEM_BOUNDS_EN
    assign err_s[0] = 1'b0;
    assign err_s[1] = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction model ----------------
    // A transaction accepted at edge t0 commits at edge t0+L-1 (data_valid in
    // the following cycle) and frees the responder at edge t0+L.
    logic [31:0] mmem [2][1024];
    int          cyc = 0;
    bit          m_active[2] = '{0, 0};
    int          m_t0   [2];
    bit          m_we   [2];
    logic [3:0]  m_mask [2];
    int          m_idx  [2];
    logic [31:0] m_data [2];
    bit          m_oob  [2];
    bit          m_valid[2] = '{0, 0};
    bit          m_err  [2] = '{0, 0};
    logic [31:0] m_dout [2] = '{32'h0, 32'h0};

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                m_active[k] = 1'b0;
                m_valid[k]  = 1'b0;
                m_err[k]    = 1'b0;
                m_dout[k]   = 32'h0;
            end
        end else begin
            cyc++;
            for (int k = 0; k < 2; k++) begin
                m_valid[k] = 1'b0;
                m_err[k]   = 1'b0;
                if (!m_active[k]) begin
                    if (req[k] === 1'b1) begin
                        m_active[k] = 1'b1;
                        m_t0[k]     = cyc;
                        m_we[k]     = we[k];
                        m_mask[k]   = msk[k];
                        m_idx[k]    = int'(adr[k][AW+1:2]);
                        m_data[k]   = din[k];
`ifdef DMEM_BOUNDS_EN
                        m_oob[k]    = (adr[k][31:AW+2] != '0);
`else
                        m_oob[k]    = 1'b0;
`endif
                    end
                end else if (cyc == m_t0[k] + lat[k]) begin
                    m_active[k] = 1'b0;
                end
                if (m_active[k] && cyc == m_t0[k] + lat[k] - 1) begin
                    m_valid[k] = 1'b1;
                    m_err[k]   = m_oob[k];
                    if (m_we[k]) begin
                        if (!m_oob[k]) begin
                            for (int b = 0; b < 4; b++) begin
                                if (m_mask[k][b]) mmem[k][m_idx[k]][8*b +: 8] = m_data[k][8*b +: 8];
                            end
                        end
                    end else begin
                        m_dout[k] = m_oob[k] ? 32'h0 : mmem[k][m_idx[k]];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst && chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("busy[%0d]", k), 32'(busy_s[k]), 32'(m_active[k]));
                chk($sformatf("data_valid[%0d]", k), 32'(valid_s[k]), 32'(m_valid[k]));
                chk($sformatf("data_out[%0d]", k), dout_s[k], m_dout[k]);
`ifdef DMEM_BOUNDS_EN
                chk($sformatf("access_err[%0d]", k), 32'(err_s[k]), 32'(m_err[k]));
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_txn(input int k, input logic w, input logic [3:0] m,
                          input logic [31:0] a, input logic [31:0] d, input bit garbage,
                          output logic [31:0] dout_o, output int busy_n, output logic err_o);
        int  guard;
        bit  acc;
        bit  done;
        busy_n = 0;
        dout_o = 32'h0;
        err_o  = 1'b0;
        req[k] = 1'b1; we[k] = w; msk[k] = m; adr[k] = a; din[k] = d;
        acc = 1'b0;
        guard = 0;
        while (!acc && guard < 20) begin
            @(negedge clk);
            guard++;
            if (busy_s[k]) acc = 1'b1;
        end
        if (!acc) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout[%0d]: busy never rose within %0d cycles", k, guard);
            req[k] = 1'b0;
        end else begin
            done = 1'b0;
            guard = 0;
            while (!done) begin
                if (busy_s[k]) busy_n++;
                if (valid_s[k]) begin
                    dout_o = dout_s[k];
                    err_o  = err_s[k];
                    req[k] = 1'b0;
                    done   = 1'b1;
                end else if (guard > 20) begin
                    n_cmp++; n_err++;
                    $display("FAIL valid_timeout[%0d]: data_valid absent after %0d cycles", k, guard);
                    req[k] = 1'b0;
                    done   = 1'b1;
                end else begin
                    if (garbage) begin
                        we[k]  = 1'($urandom_range(0, 1));
                        msk[k] = 4'($urandom);
                        adr[k] = $urandom;
                        din[k] = $urandom;
                        req[k] = 1'($urandom_range(0, 1));
                    end else begin
                        req[k] = 1'b0;
                    end
                    @(negedge clk);
                    guard++;
                end
            end
        end
    endtask

    task automatic rand_run(input int k, input int n);
        logic [31:0] a, d, r;
        logic [31:0] hi;
        int          bn;
        logic        e;
        for (int i = 0; i < n; i++) begin
            hi = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 1048575)) : 32'h0;
            a  = (hi << 12) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            d  = $urandom;
            do_txn(k, 1'($urandom_range(0, 1)), 4'($urandom), a, d, 1'b1, r, bn, e);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    logic [31:0] r_d;
    int          r_bn;
    logic        r_e;
    int          vcnt[2];
    int          guard_rst;

    initial begin
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; msk[k] = 4'h0; adr[k] = 32'h0; din[k] = 32'h0;
        end
        #12;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_busy[%0d]", k), 32'(busy_s[k]), 32'h0);
            chk($sformatf("rst_valid[%0d]", k), 32'(valid_s[k]), 32'h0);
            chk($sformatf("rst_dout[%0d]", k), dout_s[k], 32'h0);
            chk($sformatf("rst_err[%0d]", k), 32'(err_s[k]), 32'h0);
        end
        #11 rst = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;

        // Known contents for words 0..7 in both instances.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                do_txn(k, 1'b1, 4'hF, 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b0, r_d, r_bn, r_e);
            end
        end

        // Latency 1: full store, load, byte store, empty-mask store.
        do_txn(0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 1'b0, r_d, r_bn, r_e);
        chk("l1_store_busy", r_bn, 1);
        do_txn(0, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0, r_d, r_bn, r_e);
        chk("l1_load_busy", r_bn, 1);
        chk("l1_load_full", r_d, 32'hDEAD_BEEF);
        do_txn(0, 1'b1, 4'b0001, 32'h10, 32'h0000_00AA, 1'b0, r_d, r_bn, r_e);
        do_txn(0, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0, r_d, r_bn, r_e);
        chk("l1_load_lane0", r_d, 32'hDEAD_BEAA);
        do_txn(0, 1'b1, 4'b0000, 32'h10, 32'hFFFF_FFFF, 1'b0, r_d, r_bn, r_e);
        chk("l1_mask0_ack", r_bn, 1);
        do_txn(0, 1'b0, 4'h0, 32'h13, 32'h0, 1'b0, r_d, r_bn, r_e);
        chk("l1_mask0_keep", r_d, 32'hDEAD_BEAA);

        // Latency 3: busy spans 3 cycles and mid-flight input churn is ignored.
        do_txn(1, 1'b1, 4'hF, 32'h18, 32'hCAFE_F00D, 1'b0, r_d, r_bn, r_e);
        do_txn(1, 1'b0, 4'h0, 32'h18, 32'h0, 1'b1, r_d, r_bn, r_e);
        chk("l3_load_busy", r_bn, 3);
        chk("l3_load_data", r_d, 32'hCAFE_F00D);

        // Request held high: one response per Latency+1 cycles.
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b1; we[k] = 1'b0; adr[k] = 32'h10; vcnt[k] = 0;
        end
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) if (valid_s[k]) vcnt[k]++;
            if (c == 15) begin
                req[0] = 1'b0;
                req[1] = 1'b0;
            end
        end
        chk("held_l1_count", vcnt[0], 8);
        chk("held_l3_count", vcnt[1], 4);

        // Reset during WAIT of a Latency 3 store drops it.
        req[1] = 1'b1; we[1] = 1'b1; msk[1] = 4'hF; adr[1] = 32'h14; din[1] = 32'hFFFF_FFFF;
        guard_rst = 0;
        do begin
            @(negedge clk);
            guard_rst++;
        end while (!busy_s[1] && guard_rst < 10);
        req[1] = 1'b0;
        #2 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rstw_valid", 32'(valid_s[1]), 32'h0);
            chk("rstw_busy", 32'(busy_s[1]), 32'h0);
            chk("rstw_dout", dout_s[1], 32'h0);
        end
        #2 rst = 1'b1;
        do_txn(1, 1'b0, 4'h0, 32'h14, 32'h0, 1'b0, r_d, r_bn, r_e);
        chk("rstw_word_kept", r_d, 32'hA000_0005);

        // Address above the memory range.
        do_txn(0, 1'b1, 4'hF, 32'h0, 32'h1111_1111, 1'b0, r_d, r_bn, r_e);
        do_txn(0, 1'b1, 4'hF, 32'h1000, 32'h1234_5678, 1'b0, r_d, r_bn, r_e);
`ifdef DMEM_BOUNDS_EN
        chk("oob_store_err", 32'(r_e), 32'h1);
`else
        chk("wrap_store_err", 32'(r_e), 32'h0);
`endif
        do_txn(0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, r_d, r_bn, r_e);
`ifdef DMEM_BOUNDS_EN
        chk("oob_word0_kept", r_d, 32'h1111_1111);
        chk("inb_load_err", 32'(r_e), 32'h0);
        do_txn(0, 1'b0, 4'h0, 32'h1000, 32'h0, 1'b0, r_d, r_bn, r_e);
        chk("oob_load_zero", r_d, 32'h0);
        chk("oob_load_err", 32'(r_e), 32'h1);
`else
        chk("wrap_word0", r_d, 32'h1234_5678);
`endif

        // Randomized traffic on both instances concurrently.
        fork
            rand_run(0, 150);
            rand_run(1, 100);
        join

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
